// File: rtl/lcd_vga_source_if.sv
// Video-source interface: pattern controls going into the generator and the
// registered raster outputs (syncs, blank, colour, position, frame marker)
// coming out of it.
interface lcd_vga_source_if #(
  parameter int c_color_bits = 16,
  parameter int c_x_bits     = 8,
  parameter int c_y_bits     = 8
);

  // Pattern controls (sampled by the source once per frame)
  logic [1:0]              pattern_sel;
  logic [c_color_bits-1:0] solid_color;

  // Raster outputs
  logic                    hsync;
  logic                    vsync;
  logic                    blank;
  logic [c_color_bits-1:0] color;
  logic [c_x_bits-1:0]     x;
  logic [c_y_bits-1:0]     y;
  logic                    frame_start;

  // The pattern generator drives the raster and reads the controls
  modport master (
    input  pattern_sel,
    input  solid_color,
    output hsync,
    output vsync,
    output blank,
    output color,
    output x,
    output y,
    output frame_start
  );

  // The display side supplies the controls and consumes the raster
  modport slave (
    output pattern_sel,
    output solid_color,
    input  hsync,
    input  vsync,
    input  blank,
    input  color,
    input  x,
    input  y,
    input  frame_start
  );

endinterface

// File: rtl/lcd_vga_source.sv
// LCD/VGA test-pattern source. Free-running h/v raster counters gated by a
// pixel clock enable; every output is registered from the counter value of
// the same enabled edge so syncs, blank, colour and position stay aligned.
// Patterns: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid colour.
// The pattern selection and solid colour are latched only at the first
// pixel of each frame so a frame is never drawn with mixed patterns.
module lcd_vga_source #(
  parameter int c_x_size     = 240,
  parameter int c_y_size     = 240,
  parameter int c_hfront     = 8,
  parameter int c_hsync      = 16,
  parameter int c_hback      = 8,
  parameter int c_vfront     = 4,
  parameter int c_vsync      = 2,
  parameter int c_vback      = 4,
  parameter int c_color_bits = 16,
  parameter int c_x_bits     = $clog2(c_x_size),
  parameter int c_y_bits     = $clog2(c_y_size)
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               clk_pixel_ena,
  lcd_vga_source_if.master   vid
);

  // Raster geometry
  localparam int c_h_total = c_x_size + c_hfront + c_hsync + c_hback;
  localparam int c_v_total = c_y_size + c_vfront + c_vsync + c_vback;
  localparam int c_h_bits  = $clog2(c_h_total);
  localparam int c_v_bits  = $clog2(c_v_total);

  // Bar geometry: eight equal bars, tracked with a small pixel counter
  localparam int c_bar_w    = c_x_size / 8;
  localparam int c_bar_bits = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

  // Typed compare constants so every comparison is width-matched
  localparam logic [c_h_bits-1:0]   c_h_last     = c_h_bits'(c_h_total - 1);
  localparam logic [c_h_bits-1:0]   c_h_one      = c_h_bits'(1);
  localparam logic [c_h_bits-1:0]   c_x_end      = c_h_bits'(c_x_size);
  localparam logic [c_h_bits-1:0]   c_hs_start   = c_h_bits'(c_x_size + c_hfront);
  localparam logic [c_h_bits-1:0]   c_hs_end     = c_h_bits'(c_x_size + c_hfront + c_hsync);
  localparam logic [c_v_bits-1:0]   c_v_last     = c_v_bits'(c_v_total - 1);
  localparam logic [c_v_bits-1:0]   c_v_one      = c_v_bits'(1);
  localparam logic [c_v_bits-1:0]   c_y_end      = c_v_bits'(c_y_size);
  localparam logic [c_v_bits-1:0]   c_vs_start   = c_v_bits'(c_y_size + c_vfront);
  localparam logic [c_v_bits-1:0]   c_vs_end     = c_v_bits'(c_y_size + c_vfront + c_vsync);
  localparam logic [c_bar_bits-1:0] c_bar_last   = c_bar_bits'(c_bar_w - 1);
  localparam logic [c_bar_bits-1:0] c_bar_one    = c_bar_bits'(1);
  localparam logic [c_x_bits-1:0]   c_x_last_act = c_x_bits'(c_x_size - 1);

  // Raster and bar counters
  logic [c_h_bits-1:0]   h_r,       h_next_s;
  logic [c_v_bits-1:0]   v_r,       v_next_s;
  logic [c_bar_bits-1:0] bar_px_r,  bar_px_next_s;
  logic [2:0]            bar_idx_r, bar_idx_next_s;

  // Per-frame pattern shadows
  logic [1:0]              pat_shadow_r;
  logic [c_color_bits-1:0] solid_shadow_r;

  // Registered outputs
  logic                    hsync_r;
  logic                    vsync_r;
  logic                    blank_r;
  logic [c_color_bits-1:0] color_r;
  logic [c_x_bits-1:0]     x_r;
  logic [c_y_bits-1:0]     y_r;
  logic                    frame_start_r;

  // Decode of the current counter position
  logic                    origin_s;
  logic                    active_s;
  logic                    hsync_s;
  logic                    vsync_s;
  logic [1:0]              pat_eff_s;
  logic [c_color_bits-1:0] solid_eff_s;
  logic [7:0]              x8_s;
  logic [7:0]              y8_s;
  logic [15:0]             bar_color_s;
  logic [15:0]             color16_s;
  logic [c_color_bits-1:0] color_s;

  // Next raster position: h wraps at end of line, v steps on each h wrap
  always_comb begin
    h_next_s = h_r;
    v_next_s = v_r;
    if (h_r == c_h_last) begin
      h_next_s = '0;
      if (v_r == c_v_last) begin
        v_next_s = '0;
      end else begin
        v_next_s = v_r + c_v_one;
      end
    end else begin
      h_next_s = h_r + c_h_one;
    end
  end

  // Bar tracking: count pixels within a bar, step bar index every c_bar_w
  // active pixels, restart at the beginning of every line
  always_comb begin
    bar_px_next_s  = bar_px_r;
    bar_idx_next_s = bar_idx_r;
    if (h_r == c_h_last) begin
      bar_px_next_s  = '0;
      bar_idx_next_s = 3'd0;
    end else if (h_r < c_x_end) begin
      if (bar_px_r == c_bar_last) begin
        bar_px_next_s  = '0;
        bar_idx_next_s = bar_idx_r + 3'd1;
      end else begin
        bar_px_next_s  = bar_px_r + c_bar_one;
      end
    end else begin
      bar_px_next_s  = bar_px_r;
      bar_idx_next_s = bar_idx_r;
    end
  end

  // Position decode: active area, sync windows and frame origin
  always_comb begin
    origin_s = (h_r == '0) && (v_r == '0);
    active_s = (h_r < c_x_end) && (v_r < c_y_end);
    hsync_s  = (h_r >= c_hs_start) && (h_r < c_hs_end);
    vsync_s  = (v_r >= c_vs_start) && (v_r < c_vs_end);
    x8_s     = 8'(h_r);
    y8_s     = 8'(v_r);
  end

  // Pattern select: the origin pixel already uses the freshly sampled inputs
  always_comb begin
    if (origin_s) begin
      pat_eff_s   = vid.pattern_sel;
      solid_eff_s = vid.solid_color;
    end else begin
      pat_eff_s   = pat_shadow_r;
      solid_eff_s = solid_shadow_r;
    end
  end

  // Colour bar lookup, white through black left to right
  always_comb begin
    case (bar_idx_r)
      3'd0:    bar_color_s = 16'hFFFF;
      3'd1:    bar_color_s = 16'hFFE0;
      3'd2:    bar_color_s = 16'h07FF;
      3'd3:    bar_color_s = 16'h07E0;
      3'd4:    bar_color_s = 16'hF81F;
      3'd5:    bar_color_s = 16'hF800;
      3'd6:    bar_color_s = 16'h001F;
      3'd7:    bar_color_s = 16'h0000;
      default: bar_color_s = 16'h0000;
    endcase
  end

  // Pixel colour for the current position in RGB565, narrowed to the output
  always_comb begin
    case (pat_eff_s)
      2'd0:    color16_s = bar_color_s;
      2'd1:    color16_s = (x8_s[4] ^ y8_s[4]) ? 16'hFFFF : 16'h0000;
      2'd2:    color16_s = {x8_s[7:3], y8_s[7:2],
                            5'((9'(x8_s) + 9'(y8_s)) >> 4)};
      2'd3:    color16_s = 16'h0000;
      default: color16_s = 16'h0000;
    endcase
    if (pat_eff_s == 2'd3) begin
      color_s = solid_eff_s;
    end else begin
      color_s = color16_s[15 -: c_color_bits];
    end
  end

  // Counter, bar and shadow state; reset wins over the clock enable
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_r            <= '0;
      v_r            <= '0;
      bar_px_r       <= '0;
      bar_idx_r      <= 3'd0;
      pat_shadow_r   <= 2'd0;
      solid_shadow_r <= '0;
    end else if (clk_pixel_ena) begin
      h_r       <= h_next_s;
      v_r       <= v_next_s;
      bar_px_r  <= bar_px_next_s;
      bar_idx_r <= bar_idx_next_s;
      if (origin_s) begin
        pat_shadow_r   <= vid.pattern_sel;
        solid_shadow_r <= vid.solid_color;
      end
    end
  end

  // Output registers, all loaded from the same counter position
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hsync_r       <= 1'b0;
      vsync_r       <= 1'b0;
      blank_r       <= 1'b1;
      color_r       <= '0;
      x_r           <= '0;
      y_r           <= '0;
      frame_start_r <= 1'b0;
    end else if (clk_pixel_ena) begin
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      blank_r       <= ~active_s;
      color_r       <= active_s ? color_s : '0;
      frame_start_r <= origin_s;
      // x/y keep the last active coordinate through the blanking intervals
      if (active_s) begin
        x_r <= c_x_bits'(h_r);
        y_r <= c_y_bits'(v_r);
      end else if (v_r < c_y_end) begin
        x_r <= c_x_last_act;
      end
    end
  end

  assign vid.hsync       = hsync_r;
  assign vid.vsync       = vsync_r;
  assign vid.blank       = blank_r;
  assign vid.color       = color_r;
  assign vid.x           = x_r;
  assign vid.y           = y_r;
  assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_lcd_vga_source.sv
// Bench for lcd_vga_source: a frame-position reference model pushes the
// expected output set for every clock edge into a queue, and a monitor on the
// falling edge pops and compares. Directed aggregate checks cover the frame
// timing; random pattern, enable and reset activity covers the rest.
module tb_lcd_vga_source;

  localparam int HT = 272;
  localparam int VT = 250;
  localparam int XS = 240;
  localparam int YS = 240;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [15:0] color;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        frame_start;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ena = 1'b1;

  int total = 0;
  int bad = 0;

  out_t exp_q[$];

  lcd_vga_source_if vid ();

  lcd_vga_source dut (
    .clk_pixel    (clk),
    .reset        (reset),
    .clk_pixel_ena(ena),
    .vid          (vid)
  );

  always #5 clk = ~clk;

  // Reference colour from the pattern rules, using plain arithmetic
  function automatic logic [15:0] model_color(int pat, int x, int y, logic [15:0] solid);
    int idx;
    int g;
    case (pat)
      0: begin
        idx = x / (XS / 8);
        case (idx)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return (((x / 16) % 2) != ((y / 16) % 2)) ? 16'hFFFF : 16'h0000;
      2: begin
        g = ((x % 256) / 8) * 2048 + ((y % 256) / 4) * 32 + (((x + y) % 512) / 16);
        return 16'(g);
      end
      default: return solid;
    endcase
  endfunction

  // Reference model: tracks the beat number within the frame
  int          m_pos = 0;
  int          m_pat = 0;
  logic [15:0] m_solid = 16'h0000;
  out_t        m_last;
  initial begin
    int h;
    int v;
    bit act;
    out_t e;
    m_last = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pos = 0;
        m_pat = 0;
        m_solid = 16'h0000;
        e = '0;
        e.blank = 1'b1;
      end else if (ena) begin
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
          m_pat = int'(vid.pattern_sel);
          m_solid = vid.solid_color;
        end
        act = (h < XS) && (v < YS);
        e.blank = !act;
        e.hsync = (h >= XS + 8) && (h < XS + 8 + 16);
        e.vsync = (v >= YS + 4) && (v < YS + 4 + 2);
        e.color = act ? model_color(m_pat, h, v, m_solid) : 16'h0000;
        e.x = act ? 8'(h) : 8'(XS - 1);
        e.y = (v < YS) ? 8'(v) : 8'(YS - 1);
        e.frame_start = (m_pos == 0);
        m_pos = (m_pos + 1) % (HT * VT);
      end else begin
        e = m_last;
      end
      m_last = e;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare the DUT output set against the queued expectation
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.hsync = vid.hsync;
        a.vsync = vid.vsync;
        a.blank = vid.blank;
        a.color = vid.color;
        a.x = vid.x;
        a.y = vid.y;
        a.frame_start = vid.frame_start;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL beat t=%0t got hs=%0b vs=%0b bl=%0b col=%h x=%0d y=%0d fs=%0b want hs=%0b vs=%0b bl=%0b col=%h x=%0d y=%0d fs=%0b",
                   $time, a.hsync, a.vsync, a.blank, a.color, a.x, a.y, a.frame_start,
                   e.hsync, e.vsync, e.blank, e.color, e.x, e.y, e.frame_start);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int fs_cnt;
    int act_cnt;
    int hs_cnt;
    int vs_cnt;
    int run;

    // Full frame timing with the gradient, switch to solid mid-frame
    vid.pattern_sel = 2'd2;
    vid.solid_color = 16'(($urandom % 65536));
    reset = 1'b1;
    ena = 1'b1;
    step(3);
    reset = 1'b0;
    fs_cnt = 0;
    act_cnt = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1);
      if (i == 0) begin
        check("first_fs", int'(vid.frame_start), 1);
        check("first_blank", int'(vid.blank), 0);
        check("first_xy", int'(vid.x) + int'(vid.y), 0);
      end
      if (vid.frame_start === 1'b1) fs_cnt++;
      if (vid.blank === 1'b0) act_cnt++;
      if (vid.hsync === 1'b1) hs_cnt++;
      if (vid.vsync === 1'b1) vs_cnt++;
      if (i == 30000) begin
        vid.pattern_sel = 2'd3;
        vid.solid_color = 16'hF800;
      end
    end
    check("frame_starts", fs_cnt, 1);
    check("active_beats", act_cnt, XS * YS);
    check("hsync_beats", hs_cnt, 16 * VT);
    check("vsync_beats", vs_cnt, 2 * HT);
    step(1);
    check("second_fs", int'(vid.frame_start), 1);
    check("solid_origin", int'(vid.color), 16'hF800);
    step(300);

    // Colour bars with the enable toggling every cycle
    reset = 1'b1;
    vid.pattern_sel = 2'd0;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 3 * HT * 2; i++) begin
      ena = (i % 2 == 0);
      step(1);
    end
    ena = 1'b1;
    step(60 + int'($urandom_range(0, 200)));

    // Mid-frame reset, then checkerboard long enough to reach line 16
    reset = 1'b1;
    step(1);
    check("rst_blank", int'(vid.blank), 1);
    check("rst_hsync", int'(vid.hsync), 0);
    check("rst_vsync", int'(vid.vsync), 0);
    check("rst_color", int'(vid.color), 0);
    check("rst_fs", int'(vid.frame_start), 0);
    reset = 1'b0;
    vid.pattern_sel = 2'd1;
    step(1);
    check("restart_fs", int'(vid.frame_start), 1);
    check("restart_x", int'(vid.x), 0);
    check("restart_y", int'(vid.y), 0);
    step(17 * HT + 20);

    // Random patterns, colours, enables and resets
    for (int s = 0; s < 4; s++) begin
      vid.pattern_sel = 2'($urandom_range(0, 3));
      vid.solid_color = 16'($urandom % 65536);
      reset = 1'b1;
      step(int'($urandom_range(1, 2)));
      reset = 1'b0;
      run = int'($urandom_range(300, 450));
      for (int i = 0; i < run; i++) begin
        ena = ($urandom % 4) != 0;
        if (i == run / 2) begin
          vid.pattern_sel = 2'($urandom_range(0, 3));
          vid.solid_color = 16'($urandom % 65536);
        end
        step(1);
      end
      ena = 1'b1;
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_vga_source.md
LCD_VGA_SOURCE -- requirements
Module: lcd_vga_source

Interface
REQ-001 Parameters: c_x_size, 240, active pixels per line; c_y_size, 240, active lines per frame; c_hfront 8, c_hsync 16, c_hback 8, c_vfront 4, c_vsync 2, c_vback 4, porch/sync lengths in pixels or lines; c_color_bits, 16, RGB565 output width; c_x_bits, $clog2(c_x_size); c_y_bits, $clog2(c_y_size).
REQ-002 clk_pixel  in  1  single clock for the whole block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clk_pixel_ena  in  1  clock enable; default 1.
REQ-005 pattern_sel  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid.
REQ-006 solid_color  in  c_color_bits  colour for pattern 3.
REQ-007 hsync, vsync, blank  out  1 each  sync and blank, all active-high, registered.
REQ-008 color  out  c_color_bits  pixel colour, registered.
REQ-009 x  out  c_x_bits; y  out  c_y_bits  active-area position of the current output pixel.
REQ-010 frame_start  out  1  one-cycle pulse with pixel (0,0).

Function
REQ-011 H_TOTAL = c_x_size+c_hfront+c_hsync+c_hback (272 default); V_TOTAL = c_y_size+c_vfront+c_vsync+c_vback (250 default).
REQ-012 Internal h counter runs 0..H_TOTAL-1 and wraps to 0; v counter increments on h wrap, runs 0..V_TOTAL-1, wraps to 0.
REQ-013 All state, counters and outputs advance only on clk_pixel edges with clk_pixel_ena=1; with ena=0 everything holds.
REQ-014 Outputs are registered from the counter value of the same enabled edge: each output set describes one (h,v) position; all outputs change together, zero skew.
REQ-015 blank=1 when h>=c_x_size or v>=c_y_size.
REQ-016 hsync=1 for h in [c_x_size+c_hfront, c_x_size+c_hfront+c_hsync-1]; vsync=1 for all h of lines v in [c_y_size+c_vfront, c_y_size+c_vfront+c_vsync-1].
REQ-017 When blank=1, color=0; x,y hold the last active value (x=c_x_size-1 after line end, y holds through vertical blank).
REQ-018 frame_start=1 only at the output beat of (h,v)=(0,0).
REQ-019 pattern_sel and solid_color are sampled into shadow registers only at the (0,0) beat; changes mid-frame take effect next frame; the (0,0) pixel already uses the new values.
REQ-020 Pattern 0: 8 vertical bars of c_x_size/8 pixels (c_x_size multiple of 8), via a bar counter, no divider; colours left-to-right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-021 Pattern 1: color = (x[4]^y[4]) ? FFFF : 0000 (16-pixel squares).
REQ-022 Pattern 2: color = {x[7:3], y[7:2], sum[8:4]}, sum = 9-bit x+y, zero-extended.
REQ-023 Pattern 3: color = shadowed solid_color.
REQ-024 For c_color_bits < 16 the colour is the upper c_color_bits of the 16-bit value.

Reset
REQ-025 While reset=1 (sampled regardless of ena): h=v=0, bar counter 0, shadows = pattern 0 and 0; outputs blank=1, hsync=0, vsync=0, color=0, x=0, y=0, frame_start=0.
REQ-026 First enabled edge with reset=0 outputs (0,0): blank=0, frame_start=1, pattern_sel sampled.
REQ-027 Reset mid-frame restarts at REQ-025 on the next edge; no partial sync pulse continues.

Verification
REQ-028 Reset then 272*250 enabled cycles, pattern 0 -> exactly one frame_start, 240*240 cycles blank=0, 16-cycle hsync per line starting h=248, vsync for lines 244-245, second frame_start at cycle 68000.
REQ-029 Pattern 0, line 0 -> color FFFF for x 0..29, FFE0 at x=30, 0000 at x=239, 0 at h=240.
REQ-030 Pattern 1 -> (15,0)=FFFF? no: (15,0)=0000, (16,0)=FFFF, (16,16)=0000; pattern 2 at (239,239) -> {11101,111011,11101}.
REQ-031 Switch pattern_sel 0->3, solid_color=F800 mid-frame -> unchanged until next frame_start, then all active pixels F800.
REQ-032 ena toggled 1/0 every cycle -> outputs identical per enabled edge to the ena=1 run; frame takes 136000 cycles.
REQ-033 Assert reset at (100,100) for one cycle -> outputs at REQ-025 values, next enabled edge frame_start=1, x=y=0.
